// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths and FSM states for the instruction cache
package icache_pkg;

    localparam int ADDR_W          = 10;
    localparam int NUM_SETS        = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int TAG_W           = 3;
    localparam int IDX_W           = 3;
    localparam int OFF_W           = 2;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_word_select.sv
// rtl/icache_word_select.sv - 128-bit block to 32-bit word mux by word offset
module icache_word_select
    import icache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [OFF_W-1:0]   offset_i,
    output logic [WORD_W-1:0]  word_o
);

    // Word w occupies bits [32w+31:32w] of the block.
    always_comb begin
        word_o = block_i[{offset_i, 5'd0} +: WORD_W];
    end

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with block refill
module instruction_cache
    import icache_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            PC,
    output logic [WORD_W-1:0]      INSTRUCTION,
    output logic                   BUSYWAIT,
    output logic                   mem_read,
    output logic [TAG_W+IDX_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]     mem_readdata,
    input  logic                   mem_busywait
);

    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_off;
    logic             unused_pc;

    assign pc_tag    = PC[ADDR_W-1 -: TAG_W];
    assign pc_idx    = PC[ADDR_W-TAG_W-1 -: IDX_W];
    assign pc_off    = PC[OFF_W+1 -: OFF_W];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

    icache_state_e              state_q, state_d;
    logic [TAG_W+IDX_W-1:0]     miss_addr_q, miss_addr_d;
    logic                       seen_busy_q, seen_busy_d;
    logic [BLOCK_W-1:0]         fill_q;
    logic                       fill_en;
    logic [NUM_SETS-1:0]        valid_q;
    logic [TAG_W-1:0]           tag_q  [NUM_SETS];
    logic [BLOCK_W-1:0]         data_q [NUM_SETS];

    logic [IDX_W-1:0]           miss_idx;
    logic [TAG_W-1:0]           miss_tag;
    logic                       hit;

    assign miss_idx    = miss_addr_q[IDX_W-1:0];
    assign miss_tag    = miss_addr_q[TAG_W+IDX_W-1:IDX_W];
    assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign mem_address = miss_addr_q;

    icache_word_select u_word_select (
        .block_i  (data_q[pc_idx]),
        .offset_i (pc_off),
        .word_o   (INSTRUCTION)
    );

    // Next-state and outputs; a fill is only accepted after memory has shown busy.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        seen_busy_d = seen_busy_q;
        fill_en     = 1'b0;
        mem_read    = 1'b0;
        BUSYWAIT    = 1'b1;
        unique case (state_q)
            IDLE: begin
                BUSYWAIT = !hit;
                if (!hit) begin
                    miss_addr_d = {pc_tag, pc_idx};
                    seen_busy_d = 1'b0;
                    state_d     = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (mem_busywait) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !mem_busywait) begin
                    fill_en = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and valid bits; reset aborts any fill in progress.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            seen_busy_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            seen_busy_q <= seen_busy_d;
            if (state_q == UPDATE) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Fill register, tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            fill_q <= mem_readdata;
        end
        if (state_q == UPDATE) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_q;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - directed self-checking bench for instruction_cache
module tb_instruction_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_checks = 0;
    int n_fail   = 0;

    int mem_cnt   = 0;
    int mem_busy_n = 4;
    int mem_delay  = 0;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: word w of block a is {8'hCA, 2'b00, a, 16'h000w}.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[32*w +: 32] = {8'hCA, 2'b00, a, 14'd0, 2'(w)};
        end
        return b;
    endfunction

    always @(posedge CLK) mem_cnt <= mem_read ? mem_cnt + 1 : 0;

    assign mem_busywait = mem_read && (mem_cnt >= mem_delay) && (mem_cnt < mem_delay + mem_busy_n);
    assign mem_readdata = mem_busywait ? {4{32'hDEAD_DEAD}} : blk(mem_address);

    task automatic set_pc(input logic [31:0] pc);
        @(negedge CLK);
        PC = pc;
        #2;
    endtask

    // Samples once per cycle until BUSYWAIT drops; returns stall statistics.
    task automatic measure(output int busy, output int rd, output logic [5:0] first_addr,
                           output logic [5:0] last_addr, output bit to);
        bit got_first;
        busy = 0; rd = 0; first_addr = '0; last_addr = '0; to = 1'b0; got_first = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (BUSYWAIT === 1'b0) return;
            busy++;
            if (mem_read === 1'b1) begin
                rd++;
                last_addr = mem_address;
                if (!got_first) begin
                    first_addr = mem_address;
                    got_first  = 1'b1;
                end
            end
            @(negedge CLK);
            #2;
        end
        to = 1'b1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        PC    = 32'h0;
        @(negedge CLK); #2;
        @(negedge CLK); #2;
        n_checks++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL reset_busywait: got %b expected 1", BUSYWAIT); end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
        n_checks++; if (mem_address !== 6'h00) begin n_fail++; $display("FAIL reset_mem_address: got %h expected 00", mem_address); end
    endtask

    task automatic test_cold_miss;
        int busy, rd; logic [5:0] fa, la; bit to;
        mem_delay = 0; mem_busy_n = 4;
        @(negedge CLK);
        RESET = 1'b1;
        PC    = 32'h000;
        #2;
        measure(busy, rd, fa, la, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL cold_timeout: BUSYWAIT never fell"); end
        n_checks++; if (busy != 7) begin n_fail++; $display("FAIL cold_busy_cycles: got %0d expected 7", busy); end
        n_checks++; if (rd != 5) begin n_fail++; $display("FAIL cold_read_cycles: got %0d expected 5", rd); end
        n_checks++; if (fa !== 6'h00 || la !== 6'h00) begin n_fail++; $display("FAIL cold_mem_address: got %h/%h expected 00/00", fa, la); end
        n_checks++; if (INSTRUCTION !== 32'hCA00_0000) begin n_fail++; $display("FAIL cold_instr: got %h expected ca000000", INSTRUCTION); end
    endtask

    task automatic test_spatial_hits;
        logic [31:0] pcs [4];
        logic [31:0] exp [4];
        pcs = '{32'h004, 32'h008, 32'h00C, 32'h00E};
        exp = '{32'hCA00_0001, 32'hCA00_0002, 32'hCA00_0003, 32'hCA00_0003};
        for (int i = 0; i < 4; i++) begin
            set_pc(pcs[i]);
            n_checks++; if (BUSYWAIT !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL hit_stall pc=%h: busywait=%b mem_read=%b expected 0/0", pcs[i], BUSYWAIT, mem_read); end
            n_checks++; if (INSTRUCTION !== exp[i]) begin n_fail++; $display("FAIL hit_instr pc=%h: got %h expected %h", pcs[i], INSTRUCTION, exp[i]); end
        end
    endtask

    task automatic test_conflict;
        int busy, rd; logic [5:0] fa, la; bit to;
        set_pc(32'h010);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || la !== 6'h01 || INSTRUCTION !== 32'hCA01_0000) begin n_fail++; $display("FAIL conflict_first: addr %h instr %h expected 01 ca010000", la, INSTRUCTION); end
        set_pc(32'h090);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 7 || la !== 6'h09) begin n_fail++; $display("FAIL conflict_evict: busy %0d addr %h expected 7 09", busy, la); end
        n_checks++; if (INSTRUCTION !== 32'hCA09_0000) begin n_fail++; $display("FAIL conflict_evict_instr: got %h expected ca090000", INSTRUCTION); end
        set_pc(32'h010);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 7 || la !== 6'h01) begin n_fail++; $display("FAIL conflict_return: busy %0d addr %h expected 7 01", busy, la); end
    endtask

    task automatic test_mem_timing;
        int busy, rd; logic [5:0] fa, la; bit to;
        mem_delay = 1; mem_busy_n = 3;
        set_pc(32'h0A8);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 7 || rd != 5) begin n_fail++; $display("FAIL slow_mem_cycles: busy %0d reads %0d expected 7 5", busy, rd); end
        n_checks++; if (la !== 6'h0A || INSTRUCTION !== 32'hCA0A_0002) begin n_fail++; $display("FAIL slow_mem_data: addr %h instr %h expected 0a ca0a0002", la, INSTRUCTION); end
        mem_delay = 0; mem_busy_n = 1;
        set_pc(32'h0CC);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 4 || rd != 2) begin n_fail++; $display("FAIL fast_mem_cycles: busy %0d reads %0d expected 4 2", busy, rd); end
        n_checks++; if (la !== 6'h0C || INSTRUCTION !== 32'hCA0C_0003) begin n_fail++; $display("FAIL fast_mem_data: addr %h instr %h expected 0c ca0c0003", la, INSTRUCTION); end
        mem_delay = 0; mem_busy_n = 4;
    endtask

    task automatic test_pc_change;
        int busy, rd; logic [5:0] fa, la; bit to;
        set_pc(32'h020);
        @(negedge CLK); #2;
        n_checks++; if (mem_read !== 1'b1 || mem_address !== 6'h02) begin n_fail++; $display("FAIL pcchg_first_req: mem_read %b addr %h expected 1 02", mem_read, mem_address); end
        PC = 32'h044;
        #1;
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 13 || rd != 10) begin n_fail++; $display("FAIL pcchg_cycles: busy %0d reads %0d expected 13 10", busy, rd); end
        n_checks++; if (fa !== 6'h02 || la !== 6'h04) begin n_fail++; $display("FAIL pcchg_addr: first %h last %h expected 02 04", fa, la); end
        n_checks++; if (INSTRUCTION !== 32'hCA04_0001) begin n_fail++; $display("FAIL pcchg_instr: got %h expected ca040001", INSTRUCTION); end
        set_pc(32'h020);
        n_checks++; if (BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'hCA02_0000) begin n_fail++; $display("FAIL pcchg_line2: busywait %b instr %h expected 0 ca020000", BUSYWAIT, INSTRUCTION); end
    endtask

    task automatic test_reset_mid_fill;
        int busy, rd; logic [5:0] fa, la; bit to;
        set_pc(32'h100);
        @(negedge CLK); #2;
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_fill_started: mem_read %b expected 1", mem_read); end
        @(negedge CLK); #2;
        RESET = 1'b0;
        #1;
        n_checks++; if (mem_read !== 1'b0 || BUSYWAIT !== 1'b1 || mem_address !== 6'h00) begin n_fail++; $display("FAIL rmid_abort: mem_read %b busywait %b addr %h expected 0 1 00", mem_read, BUSYWAIT, mem_address); end
        @(negedge CLK);
        RESET = 1'b1;
        PC    = 32'h000;
        #2;
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 7 || rd != 5 || la !== 6'h00) begin n_fail++; $display("FAIL rmid_refetch0: busy %0d reads %0d addr %h expected 7 5 00", busy, rd, la); end
        set_pc(32'h010);
        measure(busy, rd, fa, la, to);
        n_checks++; if (to || busy != 7 || la !== 6'h01) begin n_fail++; $display("FAIL rmid_invalid1: busy %0d addr %h expected 7 01", busy, la); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hits();
        test_conflict();
        test_mem_timing();
        test_pc_change();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC in, INSTRUCTION out, BUSYWAIT out) and the block-wide instruction memory.
- It is the fetch-side counterpart of the data cache and sits directly upstream of the cpu instance in the system top; it drives that instance's INSTRUCTION input.
- Hits return the instruction in the same cycle. Misses stall the CPU through BUSYWAIT while a 16-byte block is fetched.

Parameters:
- ADDR_W, 10, byte-address bits of PC used (1 KiB instruction space)
- NUM_SETS, 8, cache lines (index width 3)
- WORDS_PER_BLOCK, 4, 32-bit words per line (128-bit block, offset 2 bits)

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- PC  in  32  fetch byte address; bits [31:ADDR_W] and [1:0] ignored
- INSTRUCTION  out  32  fetched instruction, valid when BUSYWAIT=0
- BUSYWAIT  out  1  stall to CPU; high from miss detection until the refilled line hits
- mem_read  out  1  block read request to instruction memory
- mem_address  out  6  block address {tag,index} = PC[9:4] latched at miss
- mem_readdata  in  128  returned block; word w is bits [32w+31:32w]
- mem_busywait  in  1  memory busy; block valid on first low after being high

Behaviour:
- Address split (defaults): tag = PC[9:7], index = PC[6:4], word offset = PC[3:2].
- Storage: per set, one valid bit, a 3-bit tag and a 128-bit data block. The arrays are clocked.
- hit = valid[index] && tag[index] == PC tag. This is combinational on PC.
- INSTRUCTION = data[index] word selected by the offset. It is combinational and shows don't-care content when BUSYWAIT=1.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit, mem_read = 0.
  - On a miss at posedge: latch miss_addr = PC[9:4], clear seen_busy, go to MEM_READ.
- MEM_READ:
  - mem_read = 1, mem_address = miss_addr, BUSYWAIT = 1.
  - seen_busy is set at any posedge where mem_busywait = 1.
  - Go to UPDATE at the first posedge where seen_busy = 1 and mem_busywait = 0. The same posedge captures mem_readdata into a fill register.
  - Minimum residence is 2 cycles. This tolerates both same-cycle and next-cycle busywait assertion by memory.
- UPDATE:
  - mem_read = 0, BUSYWAIT = 1.
  - At posedge: write the fill register into data[miss index], set tag[miss index] = miss tag and valid = 1, go to IDLE.
- Refill then hits in IDLE the following cycle; BUSYWAIT falls combinationally.
- Miss latency, with memory busy for N cycles: BUSYWAIT high for N+3 cycles (1 IDLE-detect + N+1 MEM_READ + 1 UPDATE).
- PC change during a refill: ignored. The refill completes for miss_addr, then IDLE re-evaluates the current PC.
- Conflict: a new tag at the same index overwrites the line with no write-back, since the cache is read-only.
- Reset (RESET=0, asynchronous):
  - State goes to IDLE immediately; all valid bits and seen_busy are cleared; miss_addr = 0.
  - Outputs during reset: mem_read = 0, mem_address = 0, and BUSYWAIT = 1 because no valid line exists. Tags and data are not reset.
  - Reset during MEM_READ aborts the fill. mem_read drops in the same cycle and no line is written.
- PC[1:0] ≠ 0: treated as aligned down; no error.

Decomposition:
- Shared package icache_pkg holds:
  - width constants TAG_W = 3, IDX_W = 3, OFF_W = 2, BLOCK_W = 128
  - the state enumeration IDLE / MEM_READ / UPDATE
- One natural sub-module, icache_word_select: a 128→32 mux driven by the offset. It is reusable by the data cache.
- The FSM and arrays stay in instruction_cache.

Test Plan:
- Cold miss: after reset release, PC = 0x000 with memory busy for 4 cycles.
  - Required: mem_read = 1 and mem_address = 6'h00 for exactly 5 cycles, BUSYWAIT = 1 for 7 cycles.
  - Then INSTRUCTION = word0 of the returned block, BUSYWAIT = 0.
- Spatial hits: after the fill, PC = 0x004, 0x008, 0x00C.
  - Required: BUSYWAIT = 0 in each cycle, INSTRUCTION = words 1, 2, 3, no mem_read.
- Conflict: load PC = 0x010 (index 1, tag 0), then PC = 0x090 (index 1, tag 1).
  - Required: the second access misses with mem_address = 6'h09.
  - Returning to 0x010 then misses again with mem_address = 6'h01.
- Slow/fast memory: mem_busywait asserted in the same cycle vs one cycle after mem_read, low for 1 cycle in between.
  - Required: the cache never leaves MEM_READ before mem_busywait has been seen high; data is captured correctly in both cases.
- Reset mid-fill: RESET = 0 during the 2nd MEM_READ cycle.
  - Required: mem_read = 0 in the same cycle, state IDLE. After release, PC = 0x000 misses again with all lines invalid.
- PC change mid-fill: PC moves 0x020 → 0x044 during MEM_READ.
  - Required: line index 2 is filled with mem_address = 6'h02, then a new miss with mem_address = 6'h04.
